reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset controller for the SoC. It takes the already-synchronized, active-high system reset, a clock-stable indication and level-sensitive soft-reset requests. It drives N_STAGES active-high reset outputs that assert together and release in a fixed order, with a programmable hold time and inter-stage gaps. It records the cause of the most recent resets in a sticky register for software.

## Interface
- N_STAGES, 3, number of staged reset outputs (>=1); stage 0 releases first.
- N_REQ, 2, number of soft-reset request inputs (>=1).
- HOLD_CYCLES, 16, consecutive clean cycles required before stage 0 releases (>=1).
- STAGE_GAP, 4, cycles between release of stage k-1 and stage k (>=1).
- clk_i  in  1  system clock; the only clock in the block.
- rst_i  in  1  synchronous, active-high reset, driven from the SoC reset synchronizer output (inverted).
- lock_i  in  1  clock-stable indication, level, synchronous to clk_i.
- req_i  in  N_REQ  soft-reset requests, level-sensitive, active-high.
- cause_clr_i  in  1  single-cycle pulse that clears cause_o.
- rst_o  out  N_STAGES  staged resets, active-high.
- done_o  out  1  high when all stages are released.
- cause_o  out  N_REQ+2  sticky causes: bit0 external reset, bit1 lock loss, bit 2+i for req_i[i].

## Operation
- States: HOLD, RELEASE, RUN.
- Reset (rst_i=1):
  - state=HOLD, counter=0, stage index=0.
  - rst_o all ones, done_o=0, cause_o=bit0 only.
- HOLD:
  - Counter increments on each edge with lock_i=1 and req_i==0.
  - Counter clears to 0 on any cycle with lock_i=0 or any req_i bit set, so the hold time is measured over consecutive clean cycles.
  - On the edge where the counter reaches HOLD_CYCLES: rst_o[0] goes to 0, state goes to RELEASE, stage index=1, counter=0.
  - If N_STAGES=1, the block goes straight to RUN and done_o=1 on that edge.
- RELEASE:
  - Counter counts edges.
  - On the edge where it reaches STAGE_GAP: rst_o[index] goes to 0, index increments, counter=0.
  - When the last stage releases, state goes to RUN and done_o=1 on the same edge.
- RUN:
  - rst_o all zero, done_o=1.
- Abort (applies in RELEASE and RUN):
  - Trigger: lock_i=0 or any req_i bit high.
  - On the next edge: all rst_o=1, done_o=0, state=HOLD, counter=0, index=0.
  - The matching cause bit is set: bit1 for lock loss, bit 2+i for req_i[i].
- Cause bits in HOLD: while in HOLD, requests and lock loss extend the hold and also set their cause bits.
- Cause update rules:
  - Bits are OR-accumulated.
  - cause_clr_i zeroes all bits, except that a bit being set in the same cycle remains set (set wins).
  - rst_i overrides cause_clr_i.
- Output ordering: rst_o is monotonic per sequence. A higher stage never releases while a lower stage is asserted. Reassertion is simultaneous for all stages.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Nominal release, taking edge E as the first edge with rst_i=0, lock_i=1 and req_i=0 (conditions held clean):
  - rst_o[0] falls at edge E+HOLD_CYCLES-1.
  - rst_o[k] falls STAGE_GAP edges after rst_o[k-1].
  - done_o rises together with rst_o[N_STAGES-1].
- Abort latency is 1 edge from trigger to all rst_o=1.
- Counter width is $clog2(max(HOLD_CYCLES,STAGE_GAP)+1). The counter never wraps: it is cleared on every state change.
- Simultaneous events:
  - rst_i has priority over everything.
  - Abort has priority over stage release in the same cycle; the release does not occur.

## Structure
- Shared header/package reset_seq_pkg holds:
  - state encodings (HOLD=0, RELEASE=1, RUN=2);
  - cause bit indices CAUSE_EXT=0 and CAUSE_LOCK=1, with CAUSE_REQ_BASE=2.
- One sub-module, reset_seq_timer: a loadable/clearable up-counter with a terminal-count compare, instantiated once and shared by HOLD and RELEASE.
- The FSM, stage index, output registers and cause register live in the top module.

## Test plan
- Default parameters, lock_i=1 throughout, rst_i deasserted -> rst_o=3'b111 until edge 15 after E, then 3'b110; 3'b100 at edge 19; 3'b000 and done_o=1 at edge 23; cause_o=4'b0001.
- lock_i low for cycles 0-9 after rst_i release, then high -> rst_o[0] falls 15 edges after lock_i rises; a 1-cycle lock glitch at hold count 10 restarts the full 16-cycle hold.
- In RUN, pulse req_i[1] for 1 cycle -> next edge rst_o=3'b111, done_o=0, cause_o=4'b1001; full sequence repeats after 16+4+4 clean cycles.
- Abort during RELEASE, lock_i=0 when rst_o=3'b110 -> next edge rst_o=3'b111, cause_o bit1 set, index restarts at 0.
- cause_clr_i pulsed in the same cycle req_i[0]=1 -> cause_o=4'b0100; a later lone clear -> 4'b0000.
- rst_i asserted mid-RELEASE with cause_clr_i=1 -> next edge rst_o all ones, done_o=0, cause_o=4'b0001.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM states and cause bit indices.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int unsigned CAUSE_EXT      = 0;
  localparam int unsigned CAUSE_LOCK     = 1;
  localparam int unsigned CAUSE_REQ_BASE = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Clearable up-counter with terminal-count compare, shared by the hold and inter-stage gap phases.
module reset_seq_timer #(
  parameter int unsigned CW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [CW-1:0] limit_i,
  output logic          tc_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Flags the edge on which an increment would reach the limit; the owner clears instead,
  // so the count never exceeds limit-1 and cannot wrap.
  assign tc_o = (count_q == (limit_i - CW'(1)));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: asserts all stage resets together, releases them in order after a
// clean hold period, and records sticky reset causes.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_STAGES    = 3,
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lock_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic                cause_clr_i,
  output logic [N_STAGES-1:0] rst_o,
  output logic                done_o,
  output logic [N_REQ+1:0]    cause_o
);

  localparam int unsigned CNT_W   = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int unsigned IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int unsigned CAUSE_W = N_REQ + 2;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     stage_q, stage_d;
  logic [N_STAGES-1:0]  rst_q, rst_d;
  logic                 done_q, done_d;
  logic [CAUSE_W-1:0]   cause_q, cause_set;

  logic                 clean;
  logic                 tmr_clr, tmr_inc, tmr_tc;
  logic [CNT_W-1:0]     tmr_limit;

  assign clean = lock_i && (req_i == '0);

  reset_seq_timer #(
    .CW (CNT_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (tmr_clr),
    .inc_i   (tmr_inc),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    rst_d     = rst_q;
    done_d    = done_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    tmr_limit = CNT_W'(HOLD_CYCLES);

    unique case (state_q)
      ST_HOLD: begin
        tmr_limit = CNT_W'(HOLD_CYCLES);
        if (!clean) begin
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          tmr_clr  = 1'b1;
          rst_d[0] = 1'b0;
          if (N_STAGES == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            stage_d = IDX_W'(1);
          end
        end else begin
          tmr_inc = 1'b1;
        end
      end

      ST_RELEASE: begin
        tmr_limit = CNT_W'(STAGE_GAP);
        // Abort is tested first so a coincident release is suppressed.
        if (!clean) begin
          tmr_clr = 1'b1;
          rst_d   = '1;
          done_d  = 1'b0;
          stage_d = '0;
          state_d = ST_HOLD;
        end else if (tmr_tc) begin
          tmr_clr = 1'b1;
          for (int unsigned k = 0; k < N_STAGES; k++) begin
            if (IDX_W'(k) == stage_q) rst_d[k] = 1'b0;
          end
          if (stage_q == IDX_W'(N_STAGES - 1)) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            stage_d = '0;
          end else begin
            stage_d = stage_q + IDX_W'(1);
          end
        end else begin
          tmr_inc = 1'b1;
        end
      end

      ST_RUN: begin
        if (!clean) begin
          tmr_clr = 1'b1;
          rst_d   = '1;
          done_d  = 1'b0;
          stage_d = '0;
          state_d = ST_HOLD;
        end
      end

      default: begin
        tmr_clr = 1'b1;
        rst_d   = '1;
        done_d  = 1'b0;
        stage_d = '0;
        state_d = ST_HOLD;
      end
    endcase
  end

  always_comb begin
    cause_set                               = '0;
    cause_set[CAUSE_LOCK]                   = !lock_i;
    cause_set[CAUSE_REQ_BASE +: N_REQ]      = req_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_HOLD;
      stage_q <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  // A cause raised in the same cycle as a clear survives it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cause_q            <= '0;
      cause_q[CAUSE_EXT] <= 1'b1;
    end else begin
      cause_q <= (cause_clr_i ? '0 : cause_q) | cause_set;
    end
  end

  assign rst_o   = rst_q;
  assign done_o  = done_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters and hand-computed expectations.
module tb_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       lock_i;
  logic [1:0] req_i;
  logic       cause_clr_i;
  logic [2:0] rst_o;
  logic       done_o;
  logic [3:0] cause_o;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  reset_sequencer #(
    .N_STAGES    (3),
    .N_REQ       (2),
    .HOLD_CYCLES (16),
    .STAGE_GAP   (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lock_i      (lock_i),
    .req_i       (req_i),
    .cause_clr_i (cause_clr_i),
    .rst_o       (rst_o),
    .done_o      (done_o),
    .cause_o     (cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs written after this are seen by the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; lock_i = 1'b1; req_i = '0; cause_clr_i = 1'b0;
    ticks(2);
    check("reset_rst_o", rst_o, 3'b111);
    check("reset_done", done_o, 1'b0);
    check("reset_cause", cause_o, 4'b0001);

    // Nominal sequence; the first edge after this point is E
    rst_i = 1'b0;
    ticks(15);
    check("nom_E14", rst_o, 3'b111);
    tick();
    check("nom_E15", rst_o, 3'b110);
    ticks(3);
    check("nom_E18", rst_o, 3'b110);
    tick();
    check("nom_E19", rst_o, 3'b100);
    ticks(3);
    check("nom_E22", rst_o, 3'b100);
    check("nom_E22_done", done_o, 1'b0);
    tick();
    check("nom_E23", rst_o, 3'b000);
    check("nom_E23_done", done_o, 1'b1);
    check("nom_cause", cause_o, 4'b0001);

    // Soft request in RUN
    req_i = 2'b10;
    tick();
    req_i = '0;
    check("req_abort_rst", rst_o, 3'b111);
    check("req_abort_done", done_o, 1'b0);
    check("req_abort_cause", cause_o, 4'b1001);
    ticks(15);
    check("req_re_E14", rst_o, 3'b111);
    tick();
    check("req_re_E15", rst_o, 3'b110);
    ticks(4);
    check("req_re_E19", rst_o, 3'b100);
    ticks(3);
    check("req_re_E22_done", done_o, 1'b0);
    tick();
    check("req_re_E23", rst_o, 3'b000);
    check("req_re_E23_done", done_o, 1'b1);

    // Lock low for 10 cycles after reset release, then a glitch at hold count 10
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; lock_i = 1'b0;
    ticks(10);
    check("lock_low_rst", rst_o, 3'b111);
    check("lock_low_cause", cause_o, 4'b0011);
    lock_i = 1'b1;
    ticks(10);
    lock_i = 1'b0;
    tick();
    lock_i = 1'b1;
    check("glitch_rst", rst_o, 3'b111);
    ticks(5);
    cause_clr_i = 1'b1;
    tick();
    cause_clr_i = 1'b0;
    ticks(9);
    check("glitch_E14", rst_o, 3'b111);
    check("lone_clear_cause", cause_o, 4'b0000);
    tick();
    check("glitch_E15", rst_o, 3'b110);

    // Lock loss during RELEASE
    lock_i = 1'b0;
    tick();
    lock_i = 1'b1;
    check("rel_abort_rst", rst_o, 3'b111);
    check("rel_abort_done", done_o, 1'b0);
    check("rel_abort_cause", cause_o, 4'b0010);
    ticks(15);
    check("rel_re_E14", rst_o, 3'b111);
    tick();
    check("rel_re_E15", rst_o, 3'b110);
    ticks(4);
    check("rel_re_E19", rst_o, 3'b100);

    // Clear coinciding with req_i[0]: set wins
    req_i = 2'b01; cause_clr_i = 1'b1;
    tick();
    req_i = '0; cause_clr_i = 1'b0;
    check("clr_set_rst", rst_o, 3'b111);
    check("clr_set_cause", cause_o, 4'b0100);
    tick();
    check("clr_hold_cause", cause_o, 4'b0100);
    cause_clr_i = 1'b1;
    tick();
    cause_clr_i = 1'b0;
    check("clr_lone_cause", cause_o, 4'b0000);

    // Abort on the same edge a stage would release
    ticks(14);
    check("prio_E15", rst_o, 3'b110);
    ticks(3);
    req_i = 2'b01;
    tick();
    req_i = '0;
    check("prio_rst", rst_o, 3'b111);
    check("prio_cause", cause_o, 4'b0100);

    // rst_i mid-RELEASE together with a clear
    ticks(16);
    check("rstmid_E15", rst_o, 3'b110);
    tick();
    rst_i = 1'b1; cause_clr_i = 1'b1;
    tick();
    rst_i = 1'b0; cause_clr_i = 1'b0;
    check("rstmid_rst", rst_o, 3'b111);
    check("rstmid_done", done_o, 1'b0);
    check("rstmid_cause", cause_o, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
